adc_sample_streamer: RTL
========================

# adc_sample_streamer

Reader side of the ADC sample buffer in data RAM. Monitors each ADC write strobe, queues the written address, reads the sample back through a dedicated RAM read port and streams it out as a 3-byte framed packet on a valid/ready byte interface, which feeds the UART transmitter. Sits beside `processor`/`RAM` in the top-level wrapper. It is the read-out counterpart of the sample-capture write path.

## Interface
- `ADDR_W`, 12: RAM word-address width.
- `DATA_W`, 32: RAM data width; the sample occupies bits [11:0].
- `FIFO_DEPTH`, 8: pending-address queue depth (power of two).
- `SYNC_BYTE`, 8'hA5: frame header byte.

- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  starts new frames when high.
- `mon_wEn`  in  1  ADC write strobe, one cycle per sample.
- `mon_addr`  in  ADDR_W  address written by that strobe.
- `mon_channel`  in  1  channel of that strobe: 0 = EMG, 1 = ECG.
- `rd_en`  out  1  RAM read request.
- `rd_addr`  out  ADDR_W  RAM read address.
- `rd_data`  in  DATA_W  RAM read data, valid 1 cycle after `rd_en`.
- `tx_data`  out  8  output byte.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte.
- `overrun`  out  1  sticky flag: a strobe was dropped because the queue was full.
- `drop_count`  out  8  number of dropped strobes; saturates at 255.

## Operation
- **Queue push:** each cycle with `mon_wEn=1` pushes `{mon_channel, mon_addr}` into the pending FIFO.
- **Queue full:** if the FIFO is full and no pop happens in the same cycle, the strobe is dropped. `overrun` is set and `drop_count` increments, saturating at 255.
- **Push and pop together:** both succeed, including when the FIFO is full.
- **FSM states:** IDLE, READ, CAPT, SYNC, HDR, LO.
  - IDLE → READ when `enable=1` and the FIFO is not empty. This cycle pops the FIFO head into `cur_addr`/`cur_ch`.
  - READ: `rd_en=1`, `rd_addr=cur_addr`. Always → CAPT.
  - CAPT: latch `sample = rd_data[11:0]`. → SYNC.
  - SYNC: byte `SYNC_BYTE`. HDR: byte `{cur_ch, 3'b000, sample[11:8]}`. LO: byte `sample[7:0]`.
  - Each byte state holds until `tx_valid && tx_ready`, then advances. LO → IDLE.
- **Frame integrity:** the header byte can never equal 8'hA5 (bits [6:4] are always 0), so a receiver resynchronises on the SYNC-followed-by-valid-HDR pattern.
- **Mid-frame `enable` drop:** the current frame completes. No new frame starts while `enable=0`. Queuing and overrun tracking continue regardless of `enable`.
- **Output stability:** `tx_data` stays stable while `tx_valid=1 && tx_ready=0`.
- **Write-after-queue:** the address queued is the strobe address. If the writer overwrites that location before READ, the newer value is sent; this is accepted behaviour.

## Timing
- **Reset values** (`reset=0`, asynchronous): state IDLE, FIFO empty, `rd_en=0`, `rd_addr=0`, `tx_valid=0`, `tx_data=0`, `overrun=0`, `drop_count=0`. Reset mid-frame aborts the frame immediately.
- `tx_valid` is a registered output, high exactly in SYNC, HDR and LO.
- **Latency**, from a strobe into an empty FIFO with idle FSM and `tx_ready=1`:
  - FIFO non-empty at cycle +1; pop at +1; READ at +2; CAPT at +3.
  - SYNC at +4, HDR at +5, LO at +6.
- **Back-to-back frames:** 6 cycles per frame minimum (1 IDLE pop cycle + READ + CAPT + 3 bytes).
- **FIFO timing:** `full`/`empty` are registered. A push is visible to a pop on the next cycle, not the same cycle.

## Structure
- Shared package `adc_stream_pkg`:
  - state enum (IDLE, READ, CAPT, SYNC, HDR, LO);
  - `SYNC_BYTE_DEFAULT = 8'hA5`;
  - `FRAME_BYTES = 3`;
  - sample field width `SAMPLE_W = 12`.
- One sub-module, `pending_addr_fifo`: synchronous FIFO of width `ADDR_W+1` and depth `FIFO_DEPTH`, with push/pop/full/empty. Simultaneous push+pop is legal when full.
- The top holds the FSM, the sample/byte registers, and the overrun/drop counter.

## Test plan
- **Single sample:** RAM[0xC80]=0x00000ABC; strobe `mon_addr`=0xC80, `mon_channel`=1, `tx_ready`=1. Expect bytes A5, 8A, BC on cycles +4, +5, +6, and `rd_en` exactly once at +2 with `rd_addr`=0xC80.
- **Backpressure:** same stimulus with `tx_ready` low for 5 cycles during HDR. HDR (0x8A) is held stable and `tx_valid` stays 1; LO follows one cycle after acceptance.
- **Overrun:** `enable`=0, 10 strobes. Expect the FIFO to hold 8, `overrun`=1, `drop_count`=2. Raise `enable`: exactly 8 frames, in strobe order.
- **Full + simultaneous:** FIFO full; pop cycle coincides with a strobe. No drop, `drop_count` unchanged, and the new address is sent last.
- **Saturation:** `enable`=0, 300 strobes. `drop_count`=255 and no wrap.
- **Reset mid-frame:** assert `reset`=0 during HDR. `tx_valid`=0 immediately. After release, no bytes are output until a new strobe arrives.

Source files
------------

// File: rtl/adc_stream_pkg.sv
// Shared types and constants for the ADC sample read-out streamer.
package adc_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPT,
        ST_SYNC,
        ST_HDR,
        ST_LO
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES       = 3;
    localparam int         SAMPLE_W          = 12;

    // Header byte: channel in bit 7, bits [6:4] forced to zero so it can never alias 8'hA5.
    function automatic logic [7:0] hdr_byte(input logic ch, input logic [SAMPLE_W-1:0] s);
        return {ch, 3'b000, s[SAMPLE_W-1:8]};
    endfunction

endpackage

// File: rtl/adc_sample_streamer_if.sv
// Bus bundle for the streamer: write-strobe monitor, RAM read port and byte stream.
interface adc_sample_streamer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              mon_wEn;
    logic [ADDR_W-1:0] mon_addr;
    logic              mon_channel;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    // Streamer side.
    modport master (
        input  mon_wEn, mon_addr, mon_channel, rd_data, tx_ready,
        output rd_en, rd_addr, tx_data, tx_valid
    );

    // Environment side (RAM, ADC writer, UART sink).
    modport slave (
        output mon_wEn, mon_addr, mon_channel, rd_data, tx_ready,
        input  rd_en, rd_addr, tx_data, tx_valid
    );
endinterface

// File: rtl/adc_sample_streamer_fifo.sv
// Pending-address FIFO: first-word fall-through, registered full/empty flags.
module pending_addr_fifo
    import adc_stream_pkg::*;
#(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             push_ok, pop_ok;

    // A pop frees a slot in the same cycle, so push is accepted when full only alongside a pop.
    assign pop_ok  = pop && !empty_q;
    assign push_ok = push && (!full_q || pop_ok);
    assign rdata   = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

    // Next pointer, occupancy and flag values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    // Pointer and flag registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/adc_sample_streamer.sv
// Queues ADC write addresses, reads each sample back and streams it as a SYNC/HDR/LO frame.
module adc_sample_streamer
    import adc_stream_pkg::*;
#(
    parameter int         ADDR_W     = 12,
    parameter int         DATA_W     = 32,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    adc_sample_streamer_if.master bus,
    output logic                  overrun,
    output logic [7:0]            drop_count
);
    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     cur_addr_q, cur_addr_d;
    logic                  cur_ch_q, cur_ch_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            drop_q, drop_d;

    logic [ADDR_W:0]       fifo_head;
    logic                  fifo_full, fifo_empty;
    logic                  pop, drop, accept;

    // Frames start only from IDLE; the head is consumed in the same cycle.
    assign pop    = (state_q == ST_IDLE) && enable && !fifo_empty;
    assign drop   = bus.mon_wEn && fifo_full && !pop;
    assign accept = tx_valid_q && bus.tx_ready;

    pending_addr_fifo #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (bus.mon_wEn),
        .pop   (pop),
        .wdata ({bus.mon_channel, bus.mon_addr}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.rd_en    = (state_q == ST_READ);
    assign bus.rd_addr  = (state_q == ST_READ) ? cur_addr_q : '0;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign overrun      = overrun_q;
    assign drop_count   = drop_q;

    // Frame FSM: output byte is loaded on entry to each byte state so tx_* are registered.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        cur_ch_d   = cur_ch_q;
        sample_d   = sample_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (state_q)
            ST_IDLE: if (pop) begin
                cur_addr_d = fifo_head[ADDR_W-1:0];
                cur_ch_d   = fifo_head[ADDR_W];
                state_d    = ST_READ;
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: begin
                sample_d   = bus.rd_data[SAMPLE_W-1:0];
                tx_data_d  = SYNC_BYTE;
                tx_valid_d = 1'b1;
                state_d    = ST_SYNC;
            end
            ST_SYNC: if (accept) begin
                tx_data_d = hdr_byte(cur_ch_q, sample_q);
                state_d   = ST_HDR;
            end
            ST_HDR: if (accept) begin
                tx_data_d = sample_q[7:0];
                state_d   = ST_LO;
            end
            ST_LO: if (accept) begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Sticky overrun and saturating drop counter; independent of enable.
    always_comb begin
        overrun_d = overrun_q | drop;
        drop_d    = drop_q;
        if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            cur_ch_q   <= 1'b0;
            sample_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            cur_ch_q   <= cur_ch_d;
            sample_q   <= sample_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            overrun_q  <= overrun_d;
            drop_q     <= drop_d;
        end
    end

endmodule
